spi_xip_sequencer: RTL and testbench

Hardware sequencer that executes flash reads through the SPI master core's register interface, so XIP fetches need no software driver. It accepts single-word read requests in the flash window and translates each one into a fixed program of SPI-core register accesses. The program is: divider, slave-select, TX words, CTRL/GO, busy poll, RX read, deselect. It sits between the APB front-end's XIP path and the SPI core's wishbone-style slave port. The SPI core issues a standard 0x03 READ with 24-bit address and 32 data bits.

---
 rtl/spi_xip_sequencer.sv | 161 ++++++++++++++++
 tb/tb_spi_xip_sequencer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_xip_sequencer.sv
// Runs a single-word flash read as a fixed program of SPI-core register accesses
// (divider, select, TX, GO, busy poll, RX, deselect) on behalf of the XIP path.
module spi_xip_sequencer #(
  parameter logic [31:0] DIVIDER  = 32'h0000_0001,
  parameter logic [7:0]  SS_MASK  = 8'h01,
  parameter logic [31:0] CTRL_CFG = 32'h0000_2440,
  parameter int          POLL_MAX = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        xip_req,
  input  logic        xip_we,
  input  logic [31:0] xip_addr,
  output logic        xip_ack,
  output logic [31:0] xip_rdata,
  output logic        xip_err,
  output logic        busy,
  output logic [4:0]  spi_adr,
  output logic [31:0] spi_dat_o,
  output logic [3:0]  spi_sel,
  output logic        spi_we,
  output logic        spi_stb,
  output logic        spi_cyc,
  input  logic [31:0] spi_dat_i,
  input  logic        spi_ack,
  input  logic        spi_err
);

  localparam int                CNT_W     = $clog2(POLL_MAX + 1);
  localparam logic [CNT_W-1:0]  POLL_LAST = CNT_W'(POLL_MAX - 1);

  localparam logic [4:0] ADR_RX0  = 5'h00;
  localparam logic [4:0] ADR_TX1  = 5'h04;
  localparam logic [4:0] ADR_CTRL = 5'h10;
  localparam logic [4:0] ADR_DIV  = 5'h14;
  localparam logic [4:0] ADR_SS   = 5'h18;
  localparam logic [31:0] CTRL_GO = 32'h0000_0100;

  typedef enum logic [3:0] {
    IDLE, W_DIV, W_SS, W_TX1, W_TX0, W_CTRL, POLL, R_RX, W_SSC, RESP, WE_RESP
  } state_t;

  state_t            r_state, w_state_nxt;
  logic              r_phase, w_phase_nxt;   // 0: setup (S) cycle, 1: access cycles
  logic [21:0]       r_addr;
  logic [31:0]       r_rdata;
  logic              r_err;
  logic [CNT_W-1:0]  r_poll_cnt;

  logic              w_access;
  logic              w_done;
  logic              w_we;
  logic [4:0]        w_adr;
  logic [31:0]       w_wdat;
  logic              w_unused_addr;

  assign w_unused_addr = ^{xip_addr[31:24], xip_addr[1:0]};

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_phase <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statements can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_access    = 1'b0;
    w_we        = 1'b0;
    w_adr       = 5'h00;
    w_wdat      = 32'h0;

    case (r_state)
      W_DIV:  begin w_access = 1'b1; w_we = 1'b1; w_adr = ADR_DIV;  w_wdat = DIVIDER; end
      W_SS:   begin w_access = 1'b1; w_we = 1'b1; w_adr = ADR_SS;   w_wdat = {24'h0, SS_MASK}; end
      W_TX1:  begin w_access = 1'b1; w_we = 1'b1; w_adr = ADR_TX1;  w_wdat = {8'h03, r_addr, 2'b00}; end
      W_TX0:  begin w_access = 1'b1; w_we = 1'b1; w_adr = ADR_RX0;  w_wdat = 32'h0; end
      W_CTRL: begin w_access = 1'b1; w_we = 1'b1; w_adr = ADR_CTRL; w_wdat = CTRL_CFG | CTRL_GO; end
      POLL:   begin w_access = 1'b1; w_adr = ADR_CTRL; end
      R_RX:   begin w_access = 1'b1; w_adr = ADR_RX0; end
      W_SSC:  begin w_access = 1'b1; w_we = 1'b1; w_adr = ADR_SS; end
      default: ;
    endcase

    w_done      = w_access & r_phase & (spi_ack | spi_err);
    w_phase_nxt = w_access & ~w_done;

    case (r_state)
      IDLE:          if (xip_req) w_state_nxt = xip_we ? WE_RESP : W_DIV;
      RESP, WE_RESP: w_state_nxt = IDLE;
      default: begin
        if (w_done) begin
          // An errored access abandons the program but still releases SS.
          if (spi_err) begin
            w_state_nxt = (r_state == W_SSC) ? RESP : W_SSC;
          end else begin
            case (r_state)
              W_DIV:  w_state_nxt = W_SS;
              W_SS:   w_state_nxt = W_TX1;
              W_TX1:  w_state_nxt = W_TX0;
              W_TX0:  w_state_nxt = W_CTRL;
              W_CTRL: w_state_nxt = POLL;
              POLL: begin
                if (!spi_dat_i[8])             w_state_nxt = R_RX;
                else if (r_poll_cnt == POLL_LAST) w_state_nxt = W_SSC;
                else                           w_state_nxt = POLL;
              end
              R_RX:    w_state_nxt = W_SSC;
              default: w_state_nxt = RESP;
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_addr     <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
      r_poll_cnt <= '0;
    end else if (r_state == IDLE && xip_req) begin
      r_err      <= 1'b0;
      r_poll_cnt <= '0;
      r_rdata    <= '0;
      if (!xip_we) r_addr <= xip_addr[23:2];
    end else if (w_done) begin
      if (spi_err) begin
        r_err   <= 1'b1;
        r_rdata <= '0;
      end else if (r_state == POLL && spi_dat_i[8]) begin
        if (r_poll_cnt == POLL_LAST) r_err <= 1'b1;
        else                         r_poll_cnt <= r_poll_cnt + CNT_W'(1);
      end else if (r_state == R_RX) begin
        // Flash bytes arrive MSB-first in RX0; the bus wants little-endian.
        r_rdata <= {spi_dat_i[7:0], spi_dat_i[15:8], spi_dat_i[23:16], spi_dat_i[31:24]};
      end
    end
  end

  assign spi_adr   = w_adr;
  assign spi_dat_o = w_wdat;
  assign spi_we    = w_we;
  assign spi_sel   = 4'hf;
  assign spi_stb   = w_access;
  assign spi_cyc   = w_access & r_phase;

  assign xip_ack   = (r_state == RESP) || (r_state == WE_RESP);
  assign xip_err   = (r_state == WE_RESP) || ((r_state == RESP) && r_err);
  assign xip_rdata = r_rdata;
  assign busy      = (r_state != IDLE) && (r_state != WE_RESP);

endmodule

// File: tb/tb_spi_xip_sequencer.sv
// Directed bench for spi_xip_sequencer: expected SPI accesses and XIP responses
// are queued by the stimulus and consumed by an independent monitor.
module tb_spi_xip_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        xip_req = 1'b0;
  logic        xip_we = 1'b0;
  logic [31:0] xip_addr = 32'h0;
  logic        xip_ack;
  logic [31:0] xip_rdata;
  logic        xip_err;
  logic        busy;
  logic [4:0]  spi_adr;
  logic [31:0] spi_dat_o;
  logic [3:0]  spi_sel;
  logic        spi_we;
  logic        spi_stb;
  logic        spi_cyc;
  logic [31:0] spi_dat_i = 32'h0;
  logic        spi_ack = 1'b0;
  logic        spi_err = 1'b0;

  spi_xip_sequencer dut (
    .clock     (clock),
    .reset     (reset),
    .xip_req   (xip_req),
    .xip_we    (xip_we),
    .xip_addr  (xip_addr),
    .xip_ack   (xip_ack),
    .xip_rdata (xip_rdata),
    .xip_err   (xip_err),
    .busy      (busy),
    .spi_adr   (spi_adr),
    .spi_dat_o (spi_dat_o),
    .spi_sel   (spi_sel),
    .spi_we    (spi_we),
    .spi_stb   (spi_stb),
    .spi_cyc   (spi_cyc),
    .spi_dat_i (spi_dat_i),
    .spi_ack   (spi_ack),
    .spi_err   (spi_err)
  );

  always #5 clock = ~clock;

  typedef struct { logic we; logic [4:0] adr; logic [31:0] dat; } acc_t;
  typedef struct { logic [31:0] rdata; logic err; int lat; } resp_t;

  acc_t        exp_acc[$];
  resp_t       exp_resp[$];
  logic [31:0] poll_q[$];

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc_cnt = 0;
  int          accept_cyc = 0;
  int          stb_cycles = 0;
  bit          sb_off = 0;
  bit          stuck_busy = 0;
  bit          inj_err = 0;
  logic [4:0]  inj_adr = 5'h00;
  logic [31:0] rx_word = 32'h0;

  always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  task automatic push_wr(input logic [4:0] adr, input logic [31:0] dat);
    acc_t a;
    a.we = 1'b1; a.adr = adr; a.dat = dat;
    exp_acc.push_back(a);
  endtask

  task automatic push_rd(input logic [4:0] adr);
    acc_t a;
    a.we = 1'b0; a.adr = adr; a.dat = 32'h0;
    exp_acc.push_back(a);
  endtask

  task automatic push_prefix(input logic [31:0] tx1);
    push_wr(5'h14, 32'h0000_0001);
    push_wr(5'h18, 32'h0000_0001);
    push_wr(5'h04, tx1);
    push_wr(5'h00, 32'h0);
    push_wr(5'h10, 32'h0000_2540);
  endtask

  task automatic push_resp(input logic [31:0] rdata, input logic err, input int lat);
    resp_t r;
    r.rdata = rdata; r.err = err; r.lat = lat;
    exp_resp.push_back(r);
  endtask

  // SPI core model: acks in the first access cycle, returns scripted CTRL/RX reads.
  always @(negedge clock) begin
    spi_ack   = 1'b0;
    spi_err   = 1'b0;
    spi_dat_i = 32'h0;
    if (spi_stb && spi_cyc) begin
      if (inj_err && spi_we && spi_adr == inj_adr) begin
        spi_err = 1'b1;
      end else begin
        spi_ack = 1'b1;
        if (!spi_we && spi_adr == 5'h10) begin
          if (stuck_busy)          spi_dat_i = 32'h0000_2540;
          else if (poll_q.size() > 0) spi_dat_i = poll_q.pop_front();
          else                     spi_dat_i = 32'h0000_2440;
        end else if (!spi_we && spi_adr == 5'h00) begin
          spi_dat_i = rx_word;
        end
      end
    end
  end

  // Monitor: pops an expectation whenever the DUT completes an access or acks.
  initial begin
    acc_t  a;
    resp_t r;
    bit    ok;
    forever begin
      @(negedge clock);
      #1;
      if (spi_stb) stb_cycles++;
      if (!sb_off) begin
        if (spi_stb && spi_cyc && (spi_ack || spi_err)) begin
          ok = (exp_acc.size() != 0);
          check("access_expected", ok, 1);
          if (ok) begin
            a = exp_acc.pop_front();
            check("acc_adr", spi_adr, a.adr);
            check("acc_we", spi_we, a.we);
            if (a.we) check("acc_wdat", spi_dat_o, a.dat);
            check("acc_sel", spi_sel, 4'hf);
          end
        end
        if (xip_ack) begin
          ok = (exp_resp.size() != 0);
          check("resp_expected", ok, 1);
          if (ok) begin
            r = exp_resp.pop_front();
            check("resp_rdata", xip_rdata, r.rdata);
            check("resp_err", xip_err, r.err);
            check("resp_latency", cyc_cnt - accept_cyc + 1, r.lat);
          end
        end
      end
    end
  end

  task automatic run_req(input logic [31:0] addr, input logic we, input logic exp_busy,
                         input int budget);
    bit done = 0;
    @(negedge clock);
    xip_req = 1'b1; xip_we = we; xip_addr = addr;
    @(posedge clock);
    #1;
    accept_cyc = cyc_cnt;
    xip_addr = ~addr;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clock);
      #2;
      if (xip_ack) begin
        done = 1;
        check("busy_at_ack", busy, exp_busy);
      end
    end
    check("ack_seen", done, 1);
    xip_req = 1'b0; xip_we = 1'b0; xip_addr = 32'h0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_stb"}, spi_stb, 0);
    check({tag, "_cyc"}, spi_cyc, 0);
    check({tag, "_we"}, spi_we, 0);
    check({tag, "_adr"}, spi_adr, 0);
    check({tag, "_dat_o"}, spi_dat_o, 0);
    check({tag, "_sel"}, spi_sel, 4'hf);
    check({tag, "_ack"}, xip_ack, 0);
    check({tag, "_err"}, xip_err, 0);
    check({tag, "_rdata"}, xip_rdata, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int stb_before;
    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs("por");
    @(negedge clock);
    reset = 1'b0;

    // Basic read, one poll; address change after acceptance must be ignored.
    rx_word = 32'h1122_3344;
    push_prefix(32'h0300_0104);
    push_rd(5'h10); push_rd(5'h00); push_wr(5'h18, 32'h0);
    push_resp(32'h4433_2211, 1'b0, 17);
    run_req(32'h3000_0104, 1'b0, 1'b1, 100);

    // Three busy polls before completion.
    poll_q = '{32'h0000_2540, 32'h0000_2540, 32'h0000_2540, 32'h0000_2440};
    rx_word = 32'hDEAD_BEEF;
    push_prefix(32'h0312_3458);
    repeat (4) push_rd(5'h10);
    push_rd(5'h00); push_wr(5'h18, 32'h0);
    push_resp(32'hEFBE_ADDE, 1'b0, 23);
    run_req(32'h0012_3458, 1'b0, 1'b1, 100);

    // GO_BSY stuck: 16 polls then deselect and error.
    stuck_busy = 1;
    push_prefix(32'h0300_0010);
    repeat (16) push_rd(5'h10);
    push_wr(5'h18, 32'h0);
    push_resp(32'h0, 1'b1, 45);
    run_req(32'h0000_0010, 1'b0, 1'b1, 200);
    stuck_busy = 0;

    // Bus error on the TX1 write: jump to deselect.
    inj_err = 1; inj_adr = 5'h04;
    push_wr(5'h14, 32'h1); push_wr(5'h18, 32'h1); push_wr(5'h04, 32'h03AB_CDEC);
    push_wr(5'h18, 32'h0);
    push_resp(32'h0, 1'b1, 9);
    run_req(32'h00AB_CDEC, 1'b0, 1'b1, 100);
    inj_err = 0;

    // Write request: immediate error, no SPI traffic, busy stays low.
    stb_before = stb_cycles;
    push_resp(32'h0, 1'b1, 1);
    run_req(32'h3000_0200, 1'b1, 1'b0, 20);
    repeat (3) @(negedge clock);
    #1;
    check("we_no_stb", stb_cycles, stb_before);

    // Reset in the middle of polling.
    sb_off = 1; stuck_busy = 1;
    @(negedge clock);
    xip_req = 1'b1; xip_we = 1'b0; xip_addr = 32'h3000_0400;
    repeat (20) @(negedge clock);
    #1;
    check("in_poll_adr", spi_adr, 5'h10);
    check("in_poll_rd", spi_we, 0);
    reset = 1'b1; xip_req = 1'b0;
    @(posedge clock);
    #1;
    check_reset_outputs("midrst");
    @(negedge clock);
    reset = 1'b0; stuck_busy = 0;
    exp_acc.delete(); exp_resp.delete(); poll_q.delete();
    sb_off = 0;

    // Full sequence after the mid-sequence reset.
    rx_word = 32'hA5A5_0F0F;
    push_prefix(32'h0300_0ABC);
    push_rd(5'h10); push_rd(5'h00); push_wr(5'h18, 32'h0);
    push_resp(32'h0F0F_A5A5, 1'b0, 17);
    run_req(32'h3000_0ABC, 1'b0, 1'b1, 100);

    repeat (3) @(negedge clock);
    #2;
    check("acc_queue_drained", exp_acc.size(), 0);
    check("resp_queue_drained", exp_resp.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
